// File: rtl/decode_stage_param_if.sv
// Decode-stage bus: fetch inputs, writeback port, immediate select and all
// decoded outputs. The slave modport is the decode stage side.
interface decode_stage_param_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            i_StallD;
  logic            i_FlushD;
  logic            i_ValidF;
  logic [31:0]     i_InstrF;
  logic [XLEN-1:0] i_PCF;
  logic [XLEN-1:0] i_PCPlus4F;
  logic            i_RegWriteW;
  logic [AW-1:0]   i_RdW;
  logic [XLEN-1:0] i_ResultW;
  logic [2:0]      i_ImmSrcD;

  logic [6:0]      o_OpCode;
  logic [2:0]      o_funct3;
  logic            o_funct7_5;
  logic            o_ValidD;
  logic [AW-1:0]   o_Rs1D;
  logic [AW-1:0]   o_Rs2D;
  logic [AW-1:0]   o_RdD;
  logic [XLEN-1:0] o_RD1D;
  logic [XLEN-1:0] o_RD2D;
  logic [XLEN-1:0] o_ImmExtD;
  logic [XLEN-1:0] o_PCD;
  logic [XLEN-1:0] o_PCPlus4D;

  modport slave (
    input  i_StallD, i_FlushD, i_ValidF, i_InstrF, i_PCF, i_PCPlus4F,
           i_RegWriteW, i_RdW, i_ResultW, i_ImmSrcD,
    output o_OpCode, o_funct3, o_funct7_5, o_ValidD, o_Rs1D, o_Rs2D, o_RdD,
           o_RD1D, o_RD2D, o_ImmExtD, o_PCD, o_PCPlus4D
  );

  modport master (
    output i_StallD, i_FlushD, i_ValidF, i_InstrF, i_PCF, i_PCPlus4F,
           i_RegWriteW, i_RdW, i_ResultW, i_ImmSrcD,
    input  o_OpCode, o_funct3, o_funct7_5, o_ValidD, o_Rs1D, o_Rs2D, o_RdD,
           o_RD1D, o_RD2D, o_ImmExtD, o_PCD, o_PCPlus4D
  );
endinterface

// File: rtl/decode_stage_param.sv
// RISC-V decode stage: F->D pipeline register with stall/flush/valid,
// register file with write-through bypass, and I/S/B/J/U immediate generator.
module decode_stage_param #(
  parameter int          XLEN      = 32,
  parameter int          NREGS     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                 i_Clk,
  input logic                 i_Reset,
  decode_stage_param_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_fmt_e;

  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcp4_q, pcp4_d;
  logic            valid_q, valid_d;

  // Flush takes priority over stall; reset is handled in the register itself.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (bus.i_FlushD) begin
      instr_d = NOP_INSTR;
      pc_d    = '0;
      pcp4_d  = '0;
      valid_d = 1'b0;
    end else if (!bus.i_StallD) begin
      instr_d = bus.i_InstrF;
      pc_d    = bus.i_PCF;
      pcp4_d  = bus.i_PCPlus4F;
      valid_d = bus.i_ValidF;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = bus.i_RegWriteW && (bus.i_RdW != '0);

  // Entry 0 is only ever cleared, so it reads as zero without a read-side mux.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      regs_q <= '{default: '0};
    end else if (wr_en) begin
      regs_q[bus.i_RdW] <= bus.i_ResultW;
    end
  end

  logic [AW-1:0]   ra1, ra2;
  logic [XLEN-1:0] rd1, rd2;

  assign ra1 = instr_q[15 +: AW];
  assign ra2 = instr_q[20 +: AW];

  always_comb begin
    rd1 = regs_q[ra1];
    rd2 = regs_q[ra2];
    if (wr_en && (bus.i_RdW == ra1)) rd1 = bus.i_ResultW;
    if (wr_en && (bus.i_RdW == ra2)) rd2 = bus.i_ResultW;
  end

  logic [31:0] imm32;
  logic        sgn;

  assign sgn = instr_q[31];

  always_comb begin
    imm32 = '0;
    case (imm_fmt_e'(bus.i_ImmSrcD))
      IMM_I:   imm32 = {{20{sgn}}, instr_q[31:20]};
      IMM_S:   imm32 = {{20{sgn}}, instr_q[31:25], instr_q[11:7]};
      IMM_B:   imm32 = {{19{sgn}}, instr_q[31], instr_q[7], instr_q[30:25],
                        instr_q[11:8], 1'b0};
      IMM_J:   imm32 = {{11{sgn}}, instr_q[31], instr_q[19:12], instr_q[20],
                        instr_q[30:21], 1'b0};
      IMM_U:   imm32 = {instr_q[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end

  // The 32-bit immediate is already sign-complete; widen it by sign extension.
  assign bus.o_ImmExtD  = XLEN'($signed(imm32));

  assign bus.o_OpCode   = instr_q[6:0];
  assign bus.o_funct3   = instr_q[14:12];
  assign bus.o_funct7_5 = instr_q[30];
  assign bus.o_ValidD   = valid_q;
  assign bus.o_Rs1D     = valid_q ? ra1 : '0;
  assign bus.o_Rs2D     = valid_q ? ra2 : '0;
  assign bus.o_RdD      = valid_q ? instr_q[7 +: AW] : '0;
  assign bus.o_RD1D     = rd1;
  assign bus.o_RD2D     = rd2;
  assign bus.o_PCD      = pc_q;
  assign bus.o_PCPlus4D = pcp4_q;
endmodule

// File: tb/tb_decode_stage_param.sv
// Bench for decode_stage_param: table of fetch vectors with a scoreboard of
// expected D-stage outputs, plus bypass, stall/flush, reset and XLEN=64 runs.
module tb_decode_stage_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_param_if #(.XLEN(32), .NREGS(32)) bus32 ();
  decode_stage_param_if #(.XLEN(64), .NREGS(16)) bus64 ();

  decode_stage_param #(.XLEN(32), .NREGS(32), .NOP_INSTR(32'h0000_0013)) u_dut (
    .i_Clk(clk), .i_Reset(rst), .bus(bus32));
  decode_stage_param #(.XLEN(64), .NREGS(16), .NOP_INSTR(32'h0000_0013)) u_dut64 (
    .i_Clk(clk), .i_Reset(rst), .bus(bus64));

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pcd, pcp4;
  } exp_t;

  typedef struct {
    logic [31:0] instr, pc;
    logic        valid;
    logic [2:0]  isrc;
    exp_t        e;
  } vec_t;

  int unsigned total = 0;
  int unsigned passed = 0;
  exp_t sb[$];
  vec_t tbl[7];
  exp_t e_rst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] pc,
                               input logic valid, input logic [2:0] isrc,
                               input logic [6:0] op, input logic [2:0] f3, input logic f75,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] imm);
    vec_t v;
    v.instr = instr; v.pc = pc; v.valid = valid; v.isrc = isrc;
    v.e.op = op; v.e.f3 = f3; v.e.f75 = f75; v.e.valid = valid;
    v.e.rs1 = rs1; v.e.rs2 = rs2; v.e.rd = rd; v.e.imm = imm;
    v.e.pcd = pc; v.e.pcp4 = pc + 32'd4;
    return v;
  endfunction

  task automatic drive_f(input vec_t v);
    bus32.i_InstrF    = v.instr;
    bus32.i_PCF       = v.pc;
    bus32.i_PCPlus4F  = v.pc + 32'd4;
    bus32.i_ValidF    = v.valid;
    bus32.i_ImmSrcD   = v.isrc;
    bus32.i_StallD    = 1'b0;
    bus32.i_FlushD    = 1'b0;
    sb.push_back(v.e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, got no expectation", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".op"},    bus32.o_OpCode,   e.op);
      check({tag, ".f3"},    bus32.o_funct3,   e.f3);
      check({tag, ".f75"},   bus32.o_funct7_5, e.f75);
      check({tag, ".valid"}, bus32.o_ValidD,   e.valid);
      check({tag, ".rs1"},   bus32.o_Rs1D,     e.rs1);
      check({tag, ".rs2"},   bus32.o_Rs2D,     e.rs2);
      check({tag, ".rd"},    bus32.o_RdD,      e.rd);
      check({tag, ".imm"},   bus32.o_ImmExtD,  e.imm);
      check({tag, ".pcd"},   bus32.o_PCD,      e.pcd);
      check({tag, ".pcp4"},  bus32.o_PCPlus4D, e.pcp4);
    end
  endtask

  initial begin
    vec_t v;
    e_rst = '{op: 7'h13, f3: 3'd0, f75: 1'b0, valid: 1'b0, rs1: 5'd0, rs2: 5'd0,
              rd: 5'd0, imm: 32'd0, pcd: 32'd0, pcp4: 32'd0};
    //            instr         pc      v  isrc  op     f3 f75 rs1 rs2 rd  imm
    tbl[0] = mkv(32'h00500093, 32'h100, 1, 3'd0, 7'h13, 0, 0,  0,  5,  1, 32'h0000_0005);
    tbl[1] = mkv(32'hFE000EE3, 32'h104, 1, 3'd2, 7'h63, 0, 1,  0,  0, 29, 32'hFFFF_FFFC);
    tbl[2] = mkv(32'hFFDFF06F, 32'h108, 1, 3'd3, 7'h6F, 7, 1, 31, 29,  0, 32'hFFFF_FFFC);
    tbl[3] = mkv(32'h12345037, 32'h10C, 1, 3'd4, 7'h37, 5, 0,  8,  3,  0, 32'h1234_5000);
    tbl[4] = mkv(32'h12345037, 32'h110, 0, 3'd7, 7'h37, 5, 0,  0,  0,  0, 32'h0000_0000);
    tbl[5] = mkv(32'h00512423, 32'h114, 1, 3'd1, 7'h23, 2, 0,  2,  5,  8, 32'h0000_0008);
    tbl[6] = mkv(32'h80000093, 32'h118, 1, 3'd0, 7'h13, 0, 0,  0,  0,  1, 32'hFFFF_F800);

    rst = 1'b1;
    bus32.i_StallD = 0; bus32.i_FlushD = 0; bus32.i_ValidF = 0; bus32.i_InstrF = '0;
    bus32.i_PCF = '0; bus32.i_PCPlus4F = '0; bus32.i_RegWriteW = 0; bus32.i_RdW = '0;
    bus32.i_ResultW = '0; bus32.i_ImmSrcD = '0;
    bus64.i_StallD = 0; bus64.i_FlushD = 0; bus64.i_ValidF = 0; bus64.i_InstrF = '0;
    bus64.i_PCF = '0; bus64.i_PCPlus4F = '0; bus64.i_RegWriteW = 0; bus64.i_RdW = '0;
    bus64.i_ResultW = '0; bus64.i_ImmSrcD = '0;

    step();
    sb.push_back(e_rst);
    step();
    pop_check("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      drive_f(tbl[i]);
      step();
      pop_check($sformatf("vec%0d", i));
    end

    // Bypass then stored value of x3 on rs1
    drive_f(mkv(32'h00018213, 32'h200, 1, 3'd0, 7'h13, 0, 0, 3, 0, 4, 32'h0));
    step();
    pop_check("byp_load");
    bus32.i_StallD = 1; bus32.i_RegWriteW = 1; bus32.i_RdW = 5'd3; bus32.i_ResultW = 32'hDEADBEEF;
    #1;
    check("byp_rd1_same_cycle", bus32.o_RD1D, 32'hDEADBEEF);
    step();
    bus32.i_RegWriteW = 0;
    #1;
    check("byp_rd1_stored", bus32.o_RD1D, 32'hDEADBEEF);
    drive_f(mkv(32'h00300233, 32'h204, 1, 3'd0, 7'h33, 0, 0, 0, 3, 4, 32'h3));
    step();
    pop_check("rs2_load");
    check("rs2_stored", bus32.o_RD2D, 32'hDEADBEEF);
    check("rs2_rd1_x0", bus32.o_RD1D, 32'h0);
    bus32.i_RegWriteW = 1; bus32.i_RdW = 5'd0; bus32.i_ResultW = 32'h1234;
    #1;
    check("x0_write_same_cycle", bus32.o_RD1D, 32'h0);
    step();
    bus32.i_RegWriteW = 0;
    #1;
    check("x0_write_after", bus32.o_RD1D, 32'h0);

    // Stall for three cycles while fetch keeps changing
    v = mkv(32'h00A28313, 32'h300, 1, 3'd0, 7'h13, 0, 0, 5, 10, 6, 32'hA);
    drive_f(v);
    step();
    pop_check("stall_load");
    for (int i = 0; i < 3; i++) begin
      bus32.i_StallD = 1;
      bus32.i_InstrF = $urandom();
      bus32.i_PCF    = $urandom();
      bus32.i_PCPlus4F = bus32.i_PCF + 32'd4;
      sb.push_back(v.e);
      step();
      pop_check($sformatf("stall%0d", i));
    end
    bus32.i_StallD = 1; bus32.i_FlushD = 1; bus32.i_ValidF = 1;
    sb.push_back(e_rst);
    step();
    pop_check("flush_over_stall");
    bus32.i_StallD = 0; bus32.i_FlushD = 0;

    // Fill x1..x31, then reset concurrently with a writeback
    for (int i = 1; i < 32; i++) begin
      bus32.i_RegWriteW = 1; bus32.i_RdW = 5'(i); bus32.i_ResultW = 32'hA500_0000 | 32'(i);
      step();
    end
    bus32.i_RegWriteW = 0;
    drive_f(mkv(32'h00728033, 32'h400, 1, 3'd0, 7'h33, 0, 0, 5, 7, 0, 32'h7));
    step();
    pop_check("fill_load");
    check("fill_rd1_x5", bus32.o_RD1D, 32'hA500_0005);
    check("fill_rd2_x7", bus32.o_RD2D, 32'hA500_0007);
    rst = 1; bus32.i_RegWriteW = 1; bus32.i_RdW = 5'd5; bus32.i_ResultW = 32'hFFFF_FFFF;
    bus32.i_InstrF = 32'h00728033; bus32.i_ValidF = 1;
    sb.push_back(e_rst);
    step();
    pop_check("midrun_reset");
    check("midrun_rd1", bus32.o_RD1D, 32'h0);
    check("midrun_rd2", bus32.o_RD2D, 32'h0);
    for (int s = 0; s < 8; s++) begin
      bus32.i_ImmSrcD = 3'(s);
      #1;
      check($sformatf("midrun_imm_src%0d", s), bus32.o_ImmExtD, 32'h0);
    end
    rst = 0; bus32.i_RegWriteW = 0;
    for (int i = 1; i < 32; i++) begin
      bus32.i_InstrF = (32'(i) << 15) | (32'(i) << 20) | 32'h33;
      bus32.i_ValidF = 1; bus32.i_ImmSrcD = 3'd0;
      step();
      check($sformatf("cleared_rd1_x%0d", i), bus32.o_RD1D, 32'h0);
      check($sformatf("cleared_rd2_x%0d", i), bus32.o_RD2D, 32'h0);
    end

    // XLEN=64, NREGS=16 instance
    bus64.i_InstrF = 32'h80000093; bus64.i_PCF = 64'h1000; bus64.i_PCPlus4F = 64'h1004;
    bus64.i_ValidF = 1; bus64.i_ImmSrcD = 3'd0;
    step();
    check("p64_imm_800", bus64.o_ImmExtD, 64'hFFFF_FFFF_FFFF_F800);
    check("p64_rd", bus64.o_RdD, 64'd1);
    check("p64_valid", bus64.o_ValidD, 64'd1);
    check("p64_pcd", bus64.o_PCD, 64'h1000);
    check("p64_pcp4", bus64.o_PCPlus4D, 64'h1004);
    bus64.i_InstrF = 32'h813F8893;
    step();
    check("p64_imm_813", bus64.o_ImmExtD, 64'hFFFF_FFFF_FFFF_F813);
    check("p64_rs1_trunc", bus64.o_Rs1D, 64'd15);
    check("p64_rs2_trunc", bus64.o_Rs2D, 64'd3);
    check("p64_rd_trunc", bus64.o_RdD, 64'd1);
    bus64.i_StallD = 1; bus64.i_RegWriteW = 1; bus64.i_RdW = 4'd15;
    bus64.i_ResultW = 64'h0123_4567_89AB_CDEF;
    #1;
    check("p64_bypass", bus64.o_RD1D, 64'h0123_4567_89AB_CDEF);
    step();
    bus64.i_RegWriteW = 0;
    #1;
    check("p64_stored", bus64.o_RD1D, 64'h0123_4567_89AB_CDEF);
    check("p64_rd2_x3", bus64.o_RD2D, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/decode_stage_param.md
# decode_stage_param

Parametrised decode stage for the pipelined RISC-V core. It holds the F→D pipeline register with stall, flush and valid-bit tracking, and contains a register file with write-through bypass. It also contains an immediate generator covering I/S/B/J/U formats. It sits between the fetch stage and the execute stage, and exposes decoded fields to the control unit and the hazard unit.

## Interface
Parameters:
- XLEN, 32, datapath width (instruction word is always 32 bits; immediates are sign-extended to XLEN).
- NREGS, 32, number of architectural registers (power of 2, 2..32); AW = $clog2(NREGS).
- NOP_INSTR, 32'h0000_0013, instruction word loaded on reset/flush (addi x0,x0,0).

Ports:
- i_Clk  in  1  sole clock; all state updates on the rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_StallD  in  1  hold the decode register.
- i_FlushD  in  1  replace the decode register contents with a bubble.
- i_ValidF  in  1  fetch-stage instruction is valid.
- i_InstrF  in  32  fetched instruction.
- i_PCF, i_PCPlus4F  in  XLEN  fetch PC and PC+4.
- i_RegWriteW  in  1  writeback enable.
- i_RdW  in  AW  writeback destination.
- i_ResultW  in  XLEN  writeback data.
- i_ImmSrcD  in  3  immediate format select.
- o_OpCode  out  7  InstrD[6:0].
- o_funct3  out  3  InstrD[14:12].
- o_funct7_5  out  1  InstrD[30].
- o_ValidD  out  1  decode slot holds a real instruction.
- o_Rs1D, o_Rs2D, o_RdD  out  AW  register fields, low AW bits; forced to 0 when o_ValidD=0.
- o_RD1D, o_RD2D  out  XLEN  register read data.
- o_ImmExtD  out  XLEN  extended immediate.
- o_PCD, o_PCPlus4D  out  XLEN  registered PCs.

## Operation
- Decode register (InstrD, PCD, PCPlus4D, ValidD): priority on each edge is reset > flush > stall > load.
  - Reset or flush: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - Stall (no flush): all fields hold.
  - Otherwise: capture i_InstrF, i_PCF, i_PCPlus4F, i_ValidF.
- Register file: NREGS×XLEN registers.
  - Written on the rising edge when i_RegWriteW=1 and i_RdW≠0.
  - Register 0 always reads 0 and is never written.
  - Reset clears all registers to 0.
- Read ports are combinational with write-through bypass. If i_RegWriteW=1, i_RdW≠0 and i_RdW equals the read address, the port returns i_ResultW; otherwise it returns the stored value.
- Read addresses are InstrD[15+:AW] and InstrD[20+:AW], taken regardless of o_ValidD.
- Immediate (ImmSrc), sign bit InstrD[31] extended to XLEN:
  - 000 I: {InstrD[31:20]}.
  - 001 S: {InstrD[31:25], InstrD[11:7]}.
  - 010 B: {InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0}.
  - 011 J: {InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0}.
  - 100 U: {InstrD[31:12], 12'b0}.
  - 101–111: 0.
- Field masking: o_Rs1D, o_Rs2D and o_RdD are 0 whenever ValidD=0, so the hazard unit sees no false dependency on a bubble. o_OpCode, o_funct3 and o_funct7_5 are never masked; on a bubble they decode as the NOP.

## Timing
- F→D latency is 1 cycle. Register read and immediate generation are combinational within the D cycle.
- Write-then-read:
  - Same-cycle W write and D read of the same register returns the new data (bypass).
  - From the next cycle, the stored value equals that data.
- Simultaneous flush and stall: flush wins.
- Simultaneous reset and writeback: reset wins; all registers read 0 next cycle.
- Reset mid-operation: at the first edge with i_Reset=1, every output returns to its reset value:
  - o_ValidD=0; o_Rs1D/o_Rs2D/o_RdD=0.
  - o_PCD=0, o_PCPlus4D=0.
  - o_OpCode=7'h13, o_funct3=0, o_funct7_5=0.
  - o_RD1D/o_RD2D=0 (unless the bypass is active).
  - o_ImmExtD=0 for any ImmSrc.
- A stall held for N cycles keeps all D outputs constant for N cycles. o_RD1D/o_RD2D may still change because of W writes to the same registers.

## Test plan
- Reset/load: after reset, o_ValidD=0 and o_OpCode=7'h13. Drive InstrF=32'h00500093 (addi x1,x0,5), PCF=0x100, ValidF=1 → next cycle o_RdD=1, o_ImmExtD=5 (ImmSrc=000), o_PCD=0x100, o_PCPlus4D=0x104.
- Bypass: with InstrD reading x3, assert RegWriteW=1, RdW=3, ResultW=0xDEADBEEF in the same cycle → o_RD1D=0xDEADBEEF that cycle and on later cycles. A write to RdW=0 with 0x1234 → x0 still reads 0.
- Stall/flush priority: assert StallD for 3 cycles while InstrF changes → outputs hold. Assert StallD and FlushD together → o_ValidD=0, o_Rs1D=o_Rs2D=o_RdD=0, o_OpCode=7'h13.
- Immediates: InstrD=32'hFE000EE3 with ImmSrc=010 → o_ImmExtD=0xFFFFFFFC (B, −4). J-type 32'hFFDFF06F with ImmSrc=011 → 0xFFFFFFFC. U-type 32'h12345037 with ImmSrc=100 → 0x12345000. ImmSrc=111 → 0.
- Mid-run reset: fill x1..x31 with nonzero values, then pulse i_Reset for 1 cycle → every register reads 0 and all outputs are at their reset values.
- Parameter sweep: XLEN=64, NREGS=16 → AW=4. I-imm 0x800 sign-extends to 0xFFFFFFFFFFFFF800. Register fields are truncated to 4 bits.
